// File: rtl/rdlvl_lane_sequencer.sv
// Read-levelling lane sequencer: drives the per-lane training engines in parallel or one lane at a time,
// applies a per-lane watchdog, aggregates done/error, and muxes the per-lane result bytes onto APB.
module rdlvl_lane_sequencer #(
    parameter int NUM_LANES  = 9,
    parameter int LANE_IDX_W = 4,
    parameter int ADDR_LSB   = 6,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                   SCLK,
    input  logic                   reset_n,
    input  logic                   dfi_rdlvl_en,
    input  logic                   mode_serial,
    input  logic [NUM_LANES-1:0]   lane_mask,
    input  logic [TIMEOUT_W-1:0]   timeout_limit,
    input  logic [NUM_LANES-1:0]   lane_resp,
    input  logic [NUM_LANES-1:0]   lane_error,
    output logic [NUM_LANES-1:0]   lane_en,
    output logic                   dfi_rdlvl_resp,
    output logic                   rd_training_error,
    output logic [NUM_LANES-1:0]   lane_err_status,
    output logic [NUM_LANES-1:0]   lane_timeout_status,
    output logic                   busy,
    input  logic [15:0]            apb_addr,
    input  logic                   apb_re,
    input  logic                   read_access,
    input  logic [NUM_LANES*8-1:0] lane_apb_data,
    output logic [7:0]             apb_data_out,
    output logic [NUM_LANES-1:0]   lane_read_access
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN_PAR = 3'd1,
        S_RUN_SER = 3'd2,
        S_NEXT    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   en_q;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic [NUM_LANES-1:0]   done_q, done_d;
    logic [NUM_LANES-1:0]   lane_en_q, lane_en_d;
    logic [NUM_LANES-1:0]   err_q, err_d;
    logic [NUM_LANES-1:0]   to_q, to_d;
    logic [LANE_IDX_W-1:0]  ptr_q, ptr_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d, timer_inc;
    logic [7:0]             rd_data_q, rd_data_d;
    logic [NUM_LANES-1:0]   rd_strb_q, rd_strb_d;

    logic                   start, abort, tmo_hit, next_vld;
    logic [NUM_LANES-1:0]   hit;
    logic [LANE_IDX_W-1:0]  first_idx, next_idx, apb_idx;
    logic                   unused_addr;

    function automatic logic [NUM_LANES-1:0] onehot(input logic [LANE_IDX_W-1:0] idx);
        onehot = '0;
        for (int i = 0; i < NUM_LANES; i++) onehot[i] = (LANE_IDX_W'(i) == idx);
    endfunction

    assign start     = (state_q == S_IDLE) && dfi_rdlvl_en && !en_q;
    assign abort     = !dfi_rdlvl_en &&
                       (state_q == S_RUN_PAR || state_q == S_RUN_SER || state_q == S_NEXT);
    assign hit       = lane_en_q & lane_resp;
    assign timer_inc = (&timer_q) ? timer_q : timer_q + TIMEOUT_W'(1);
    assign tmo_hit   = (timeout_limit != '0) && (timer_q == timeout_limit - TIMEOUT_W'(1));

    // Descending scan so the last match wins, i.e. the lowest qualifying lane.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        next_vld  = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_mask[i]) first_idx = LANE_IDX_W'(i);
            if (mask_q[i] && (LANE_IDX_W'(i) > ptr_q)) begin
                next_idx = LANE_IDX_W'(i);
                next_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        done_d    = done_q;
        lane_en_d = lane_en_q;
        err_d     = err_q;
        to_d      = to_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        if (abort) begin
            lane_en_d = '0;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_d  = lane_mask;
                        done_d  = '0;
                        err_d   = '0;
                        to_d    = '0;
                        timer_d = '0;
                        ptr_d   = '0;
                        if (lane_mask == '0) begin
                            state_d = S_DONE;
                        end else if (mode_serial) begin
                            ptr_d     = first_idx;
                            lane_en_d = onehot(first_idx);
                            state_d   = S_RUN_SER;
                        end else begin
                            lane_en_d = lane_mask;
                            state_d   = S_RUN_PAR;
                        end
                    end
                end
                S_RUN_PAR: begin
                    timer_d   = timer_inc;
                    done_d    = done_q | hit;
                    err_d     = err_q | (hit & lane_error);
                    lane_en_d = lane_en_q & ~hit;
                    // A response landing on the watchdog cycle counts as done, not timed out.
                    if (done_d == mask_q) begin
                        state_d = S_DONE;
                    end else if (tmo_hit) begin
                        to_d      = to_q | (mask_q & ~done_d);
                        lane_en_d = '0;
                        state_d   = S_DONE;
                    end
                end
                S_RUN_SER: begin
                    timer_d = timer_inc;
                    if (|hit) begin
                        err_d     = err_q | (hit & lane_error);
                        lane_en_d = '0;
                        state_d   = S_NEXT;
                    end else if (tmo_hit) begin
                        to_d      = to_q | lane_en_q;
                        lane_en_d = '0;
                        state_d   = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (next_vld) begin
                        ptr_d     = next_idx;
                        timer_d   = '0;
                        lane_en_d = onehot(next_idx);
                        state_d   = S_RUN_SER;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!dfi_rdlvl_en) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign apb_idx     = apb_addr[ADDR_LSB+LANE_IDX_W-1:ADDR_LSB];
    assign unused_addr = ^apb_addr;

    // Out-of-range indices match no lane, so data and strobe fall back to zero.
    always_comb begin
        rd_data_d = '0;
        rd_strb_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (apb_idx == LANE_IDX_W'(i)) begin
                rd_data_d    = lane_apb_data[i*8 +: 8];
                rd_strb_d[i] = apb_re & read_access;
            end
        end
    end

    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            mask_q    <= '0;
            done_q    <= '0;
            lane_en_q <= '0;
            err_q     <= '0;
            to_q      <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
            rd_data_q <= '0;
            rd_strb_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= dfi_rdlvl_en;
            mask_q    <= mask_d;
            done_q    <= done_d;
            lane_en_q <= lane_en_d;
            err_q     <= err_d;
            to_q      <= to_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            rd_data_q <= rd_data_d;
            rd_strb_q <= rd_strb_d;
        end
    end

    assign lane_en             = lane_en_q;
    assign busy                = (state_q != S_IDLE);
    assign dfi_rdlvl_resp      = (state_q == S_DONE);
    assign rd_training_error   = (state_q == S_DONE) && |(err_q | to_q);
    assign lane_err_status     = err_q;
    assign lane_timeout_status = to_q;
    assign apb_data_out        = rd_data_q;
    assign lane_read_access    = rd_strb_q;

endmodule

// File: tb/tb_rdlvl_lane_sequencer.sv
// Bench for rdlvl_lane_sequencer: per-cycle expectations derived from lane latencies go into a
// scoreboard keyed by cycle number; a monitor pops and compares them on the falling edge.
module tb_rdlvl_lane_sequencer;
    localparam int NL = 9;

    logic            SCLK = 1'b0;
    logic            reset_n = 1'b0;
    logic            dfi_rdlvl_en = 1'b0;
    logic            mode_serial = 1'b0;
    logic [NL-1:0]   lane_mask = '0;
    logic [15:0]     timeout_limit = '0;
    logic [NL-1:0]   lane_resp = '0;
    logic [NL-1:0]   lane_error = '0;
    logic [15:0]     apb_addr = '0;
    logic            apb_re = 1'b0;
    logic            read_access = 1'b0;
    logic [NL*8-1:0] lane_apb_data = '0;
    logic [NL-1:0]   lane_en, lane_err_status, lane_timeout_status, lane_read_access;
    logic            dfi_rdlvl_resp, rd_training_error, busy;
    logic [7:0]      apb_data_out;

    rdlvl_lane_sequencer #(.NUM_LANES(NL), .LANE_IDX_W(4), .ADDR_LSB(6), .TIMEOUT_W(16)) dut (
        .SCLK(SCLK), .reset_n(reset_n), .dfi_rdlvl_en(dfi_rdlvl_en), .mode_serial(mode_serial),
        .lane_mask(lane_mask), .timeout_limit(timeout_limit), .lane_resp(lane_resp),
        .lane_error(lane_error), .lane_en(lane_en), .dfi_rdlvl_resp(dfi_rdlvl_resp),
        .rd_training_error(rd_training_error), .lane_err_status(lane_err_status),
        .lane_timeout_status(lane_timeout_status), .busy(busy), .apb_addr(apb_addr),
        .apb_re(apb_re), .read_access(read_access), .lane_apb_data(lane_apb_data),
        .apb_data_out(apb_data_out), .lane_read_access(lane_read_access)
    );

    always #5 SCLK = ~SCLK;

    int cyc = 0;
    always @(posedge SCLK) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        bit            apb;
        bit            chk_stat;
        logic          busy, resp, rderr;
        logic [NL-1:0] en, err, to, strb;
        logic [7:0]    dat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Training-engine model knobs, owned by the stimulus process between runs.
    int            lat[NL];
    logic [NL-1:0] lerr = '0;
    bit            noise = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, c, act, exp);
        end
    endtask

    task automatic push(input int c, input bit is_apb, input logic b, input logic r,
                        input logic [NL-1:0] en, input bit cs, input logic [NL-1:0] er,
                        input logic [NL-1:0] to, input logic [7:0] d, input logic [NL-1:0] st);
        exp_t e;
        e.cyc = c; e.apb = is_apb; e.chk_stat = cs; e.busy = b; e.resp = r;
        e.en = en; e.err = er; e.to = to; e.dat = d; e.strb = st;
        e.rderr = r & (|(er | to));
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge SCLK);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    chk("stale_expectation", 32'(cyc), 32'(e.cyc), cyc);
                end else if (e.apb) begin
                    chk("apb_data_out", 32'(apb_data_out), 32'(e.dat), cyc);
                    chk("lane_read_access", 32'(lane_read_access), 32'(e.strb), cyc);
                end else begin
                    chk("lane_en", 32'(lane_en), 32'(e.en), cyc);
                    chk("dfi_rdlvl_resp", 32'(dfi_rdlvl_resp), 32'(e.resp), cyc);
                    chk("busy", 32'(busy), 32'(e.busy), cyc);
                    if (e.chk_stat) begin
                        chk("lane_err_status", 32'(lane_err_status), 32'(e.err), cyc);
                        chk("lane_timeout_status", 32'(lane_timeout_status), 32'(e.to), cyc);
                        chk("rd_training_error", 32'(rd_training_error), 32'(e.rderr), cyc);
                    end
                end
            end
        end
    end

    // Training engines: respond lat[i] cycles after seeing their enable; optional noise on idle lanes.
    initial begin
        int cnt[NL];
        for (int i = 0; i < NL; i++) cnt[i] = 0;
        forever begin
            @(negedge SCLK);
            for (int i = 0; i < NL; i++) begin
                if (lane_en[i]) begin
                    cnt[i]++;
                    lane_resp[i]  = (cnt[i] == lat[i]);
                    lane_error[i] = (cnt[i] == lat[i]) ? lerr[i] : 1'($urandom);
                end else begin
                    cnt[i] = 0;
                    lane_resp[i]  = noise && ($urandom_range(0, 3) == 0);
                    lane_error[i] = 1'($urandom);
                end
            end
        end
    end

    // One training run. ab_k: -1 no abort, -2 abort at a random cycle, else drop en at that cycle index.
    task automatic do_run(input bit ser, input logic [NL-1:0] msk, input int lim, input int hold, input int ab_req);
        int            eff[NL];
        int            ce[NL];
        logic [NL-1:0] en_at[512];
        logic [NL-1:0] tmo, errx, perr, pto;
        int            k_done, s, c0, last, ab_k;
        bit            cs;
        tmo = '0; errx = '0; k_done = 0; s = 0;
        for (int k = 0; k < 512; k++) en_at[k] = '0;
        for (int i = 0; i < NL; i++) begin
            eff[i] = 0; ce[i] = 0;
            if (msk[i]) begin
                if (lim != 0 && lat[i] > lim) begin tmo[i] = 1'b1; eff[i] = lim; end
                else begin eff[i] = lat[i]; errx[i] = lerr[i]; end
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (msk[i]) begin
                if (ser) begin
                    for (int k = s; k < s + eff[i]; k++) en_at[k][i] = 1'b1;
                    ce[i] = s + eff[i];
                    s = s + eff[i] + 1;
                    k_done = s;
                end else begin
                    for (int k = 0; k < eff[i]; k++) en_at[k][i] = 1'b1;
                    ce[i] = eff[i];
                    if (eff[i] > k_done) k_done = eff[i];
                end
            end
        end
        ab_k = ab_req;
        if (ab_req == -2) ab_k = (k_done > 0) ? $urandom_range(0, k_done - 1) : -1;
        mode_serial = ser; lane_mask = msk; timeout_limit = 16'(lim); dfi_rdlvl_en = 1'b1;
        c0 = cyc + 1;
        last = (ab_k >= 0) ? ab_k : k_done + hold;
        for (int k = 0; k <= last; k++) begin
            if (k < k_done) push(c0 + k, 0, 1, 0, en_at[k], 0, '0, '0, '0, '0);
            else            push(c0 + k, 0, 1, 1, '0, 1, errx, tmo, '0, '0);
        end
        perr = errx; pto = tmo; cs = 1'b1;
        if (ab_k >= 0) begin
            perr = '0; pto = '0;
            for (int i = 0; i < NL; i++) begin
                if (msk[i] && ce[i] <= ab_k) begin perr[i] = errx[i]; pto[i] = tmo[i]; end
                if (msk[i] && ce[i] == ab_k + 1) cs = 1'b0;
            end
        end
        for (int k = last + 1; k <= last + 2; k++) push(c0 + k, 0, 0, 0, '0, cs, perr, pto, '0, '0);
        repeat (last + 1) @(negedge SCLK);
        dfi_rdlvl_en = 1'b0;
        repeat (3) @(negedge SCLK);
    endtask

    task automatic apb_step(input int idx, input bit re, input bit ra);
        logic [7:0]    d;
        logic [NL-1:0] st;
        logic [3:0]    i4;
        i4 = 4'(idx);
        apb_addr = {6'($urandom), i4, 6'($urandom)};
        apb_re = re; read_access = ra;
        d = '0; st = '0;
        if (idx < NL) begin
            d = lane_apb_data[idx*8 +: 8];
            if (re && ra) st = NL'(1) << idx;
        end
        push(cyc + 1, 1, 0, 0, '0, 0, '0, '0, d, st);
        @(negedge SCLK);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) lat[i] = 1;
        repeat (3) @(negedge SCLK);
        push(cyc + 1, 0, 0, 0, '0, 1, '0, '0, '0, '0);
        push(cyc + 1, 1, 0, 0, '0, 0, '0, '0, '0, '0);
        repeat (2) @(negedge SCLK);
        reset_n = 1'b1;
        @(negedge SCLK);

        // Parallel, staggered responses, lane 3 errors
        for (int i = 0; i < NL; i++) lat[i] = 5 + i;
        lerr = 9'h008;
        do_run(0, 9'h1FF, 0, 2, -1);
        // Serial over lanes 0, 2, 8
        lat[0] = 3; lat[2] = 4; lat[8] = 2; lerr = '0;
        do_run(1, 9'h105, 0, 1, -1);
        // Watchdog: lane 1 silent, then lane 1 answering on the watchdog cycle
        lat[0] = 4; lat[1] = 40;
        do_run(0, 9'h003, 10, 1, -1);
        lat[1] = 10;
        do_run(0, 9'h003, 10, 1, -1);
        // Serial watchdog on the middle lane
        lat[0] = 2; lat[2] = 30; lat[8] = 3; lerr = 9'h100;
        do_run(1, 9'h105, 5, 1, -1);
        // Abort mid serial, then a fresh clean run
        for (int i = 0; i < NL; i++) lat[i] = 6;
        lerr = 9'h001;
        do_run(1, 9'h105, 0, 0, 9);
        lerr = '0;
        do_run(1, 9'h105, 0, 1, -1);
        // Empty mask in both modes
        do_run(0, '0, 5, 1, -1);
        do_run(1, '0, 0, 1, -1);

        // APB readback
        for (int k = 0; k < NL; k++) lane_apb_data[k*8 +: 8] = 8'hA0 + 8'(k);
        for (int k = 0; k < 10; k++) apb_step(k, 1, 1);
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < NL; k++) lane_apb_data[k*8 +: 8] = 8'($urandom);
            apb_step($urandom_range(0, 15), 1'($urandom), 1'($urandom));
        end
        apb_re = 1'b0; read_access = 1'b0;
        @(negedge SCLK);

        // Randomized runs with noise on idle lanes
        noise = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [NL-1:0] m;
            int            lim;
            m   = ($urandom_range(0, 7) == 0) ? '0 : NL'($urandom);
            lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 14);
            for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, 12);
            lerr = NL'($urandom) & NL'($urandom);
            do_run(1'($urandom), m, lim, $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? -2 : -1);
        end
        noise = 1'b0;

        repeat (2) @(negedge SCLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0, cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rdlvl_lane_sequencer.md
Name: rdlvl_lane_sequencer

Overview:
Parametrised read-levelling lane controller that sits between the DFI read-levelling request and the per-lane read-training engines. It starts each lane's training engine, either all masked lanes together or one lane at a time, and collects per-lane responses and errors. It enforces a per-lane timeout and returns one aggregated response and error. It also provides a registered APB readback mux over the per-lane result bytes, so lane count, training order and watchdog are runtime/parameter controlled.

Parameters:
NUM_LANES, 9, number of DQS lanes (1..16).
LANE_IDX_W, 4, width of lane index decoded from apb_addr; 2**LANE_IDX_W >= NUM_LANES.
ADDR_LSB, 6, lowest apb_addr bit of the lane index field.
TIMEOUT_W, 16, width of the per-lane cycle timer.

Ports:
SCLK  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
dfi_rdlvl_en  in  1  training request from controller; level, held for the whole run.
mode_serial  in  1  0 = parallel, 1 = serial lane-by-lane; sampled at start.
lane_mask  in  NUM_LANES  1 = lane takes part; sampled at start.
timeout_limit  in  TIMEOUT_W  per-lane cycle limit; 0 = watchdog disabled.
lane_resp  in  NUM_LANES  per-lane done pulse/level from training engines.
lane_error  in  NUM_LANES  per-lane error; qualified by lane_resp.
lane_en  out  NUM_LANES  per-lane training enable.
dfi_rdlvl_resp  out  1  aggregated done.
rd_training_error  out  1  any lane error or timeout.
lane_err_status  out  NUM_LANES  sticky per-lane error.
lane_timeout_status  out  NUM_LANES  sticky per-lane timeout.
busy  out  1  high in any state other than IDLE.
apb_addr  in  16  internal APB address.
apb_re  in  1  APB read enable.
read_access  in  1  APB read strobe.
lane_apb_data  in  NUM_LANES*8  per-lane result bytes, lane i at [8i+7:8i].
apb_data_out  out  8  selected lane byte.
lane_read_access  out  NUM_LANES  one-hot read strobe to the selected lane.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; timer, pointer and captured mask 0.
- Start: en_d is registered dfi_rdlvl_en. Start = dfi_rdlvl_en & ~en_d while in IDLE.
  - On start: capture mask/mode, clear both status vectors, timer = 0.
  - If mask == 0, go to DONE.
  - Else in parallel mode: lane_en = mask, go to RUN_PAR.
  - Else in serial mode: ptr = lowest set mask bit, lane_en = one-hot(ptr), go to RUN_SER.
  - lane_en changes on the cycle after the start edge.
- RUN_PAR:
  - For each i with lane_en[i] & lane_resp[i]: set done[i]; latch lane_error[i] into lane_err_status[i]; clear lane_en[i] next cycle.
  - Timer increments every cycle.
  - When done == captured mask, go to DONE.
  - If timeout_limit != 0 and timer == timeout_limit-1 with lanes still pending, then next cycle: set lane_timeout_status for the pending lanes, clear lane_en, go to DONE.
- RUN_SER:
  - On lane_resp[ptr]: latch the error, clear lane_en, go to NEXT.
  - On timeout: flag ptr, clear lane_en, go to NEXT.
- NEXT (one idle cycle, all lane_en = 0):
  - ptr = next set mask bit above ptr, timer = 0, lane_en = one-hot, go back to RUN_SER.
  - If no set bit remains, go to DONE.
- Simultaneous lane_resp and timeout on the same cycle: resp wins, no timeout flag.
- lane_resp on an unenabled lane is ignored.
- Timer saturates at all-ones.
- DONE:
  - dfi_rdlvl_resp = 1.
  - rd_training_error = |(lane_err_status | lane_timeout_status).
  - Both hold while dfi_rdlvl_en is high. When dfi_rdlvl_en falls, go to IDLE and both outputs drop next cycle.
  - Status vectors persist until the next start.
- Abort: dfi_rdlvl_en low while in RUN_PAR, RUN_SER or NEXT.
  - Next cycle: lane_en = 0, go to IDLE.
  - dfi_rdlvl_resp never asserts; status keeps partial results.
  - A new start requires a fresh rising edge.
- APB mux: idx = apb_addr[ADDR_LSB+LANE_IDX_W-1:ADDR_LSB].
  - apb_data_out is registered, latency 1: lane byte idx if idx < NUM_LANES, else 0.
  - lane_read_access is registered, latency 1: one-hot(idx) & {read_access & apb_re}; all 0 if idx out of range.
- Inputs are synchronous to SCLK; no CDC inside.

Test Plan:
- Parallel, NUM_LANES=9, mask=9'h1FF, limit=0, lane_resp staggered at cycles 5..13, lane 3 with error -> each lane_en drops 1 cycle after its resp; dfi_rdlvl_resp=1 one cycle after the last resp; lane_err_status=9'h008; rd_training_error=1.
- Serial, mask=9'h105 -> lane_en sequence is 9'h001, 0, 9'h004, 0, 9'h100 (0 = one-cycle NEXT gap); DONE after lane 8 resp; no error.
- Timeout, parallel, mask=9'h003, limit=10, only lane 0 responds -> lane_timeout_status=9'h002 with lane_en cleared at cycle 10 after start; resp=1, error=1. Repeat with lane 1 resp on the timeout cycle -> no timeout flag.
- Abort: drop dfi_rdlvl_en mid RUN_SER -> lane_en=0 next cycle, busy=0, dfi_rdlvl_resp stays 0. Re-raise -> fresh run with status cleared.
- mask=0 -> dfi_rdlvl_resp=1 within 2 cycles of the start edge, error=0, lane_en never asserted.
- APB: lane_apb_data lane k = 8'hA0+k; apb_addr[9:6]=k for k=0..9 with apb_re=read_access=1 -> apb_data_out=8'hA0+k one cycle later, lane_read_access=1<<k. For k=9: data 0, strobe 0.
